bird_column: RTL and testbench

Parametrised bird-position controller for the Flappy Bird LED matrix. It is the successor to the per-LED light cell: one block now owns a whole column of ROWS lights and drives them as a one-hot vector. Each game tick the block applies a jump or gravity, saturates at the ceiling, and detects crashes against the ground or a pipe mask. It sits between the key input and the column driver, and reports its crash status to the game controller.

---
 rtl/bird_column.sv | 139 +++++++++++++
 tb/tb_bird_column.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bird_column.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bird_column                                                   |
// | Purpose  : Bird-position controller for one LED-matrix column. Applies   |
// |            jump or gravity on each game tick, saturates at the ceiling,  |
// |            and latches a crash against the ground or a pipe.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bird_column #(
  parameter int ROWS       = 8,
  parameter int START_ROW  = 4,
  parameter int JUMP       = 1,
  parameter int FALL_DELAY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    gameOver,
  input  logic [ROWS-1:0]         wall,
  output logic [ROWS-1:0]         lightOn,
  output logic [$clog2(ROWS)-1:0] pos,
  output logic                    crashed
);

  localparam int POS_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(FALL_DELAY + 1);

  localparam logic [POS_W-1:0] c_START    = POS_W'(START_ROW);
  localparam logic [POS_W:0]   c_TOP_WIDE = (POS_W + 1)'(ROWS - 1);
  localparam logic [POS_W:0]   c_JUMP     = (POS_W + 1)'(JUMP);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(FALL_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLY     = 2'd1,
    S_CRASHED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_posNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_pending;
  logic             w_pendingNext;
  logic             r_crashed;
  logic             w_crashedNext;

  logic             w_tick;
  logic             w_jump;
  logic [POS_W:0]   w_jumpSum;
  logic [POS_W-1:0] w_posJump;

  // Register all block state; reset restores the parked bird immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pos     <= c_START;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_crashed <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pos     <= w_posNext;
      r_cnt     <= w_cntNext;
      r_pending <= w_pendingNext;
      r_crashed <= w_crashedNext;
    end
  end

  // Next-state logic: movement only on unfrozen ticks, key capture every clk.
  always_comb begin
    w_stateNext   = r_state;
    w_posNext     = r_pos;
    w_cntNext     = r_cnt;
    w_crashedNext = r_crashed;
    // A press between ticks is remembered; a freeze request drops it.
    w_pendingNext = r_pending | (up & ~gameOver);

    w_tick    = enable & ~gameOver;
    // A press on the tick cycle itself counts for that tick.
    w_jump    = r_pending | up;
    // Widened sum so the ceiling clamp cannot wrap.
    w_jumpSum = {1'b0, r_pos} + c_JUMP;
    w_posJump = (w_jumpSum > c_TOP_WIDE) ? c_TOP_WIDE[POS_W-1:0]
                                         : w_jumpSum[POS_W-1:0];

    if (w_tick) begin
      w_pendingNext = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_jump) begin
            w_posNext   = w_posJump;
            w_cntNext   = '0;
            w_stateNext = S_FLY;
          end
        end
        S_FLY: begin
          if (w_jump) begin
            w_posNext = w_posJump;
            w_cntNext = '0;
          end else if (r_cnt == c_CNT_LAST) begin
            w_cntNext = '0;
            if (r_pos == '0) begin
              // Falling out of the bottom row is a ground crash.
              w_stateNext   = S_CRASHED;
              w_crashedNext = 1'b1;
            end else begin
              w_posNext = r_pos - POS_W'(1);
            end
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
          // Pipe hit is judged at the row the bird ends up in.
          if (wall[w_posNext]) begin
            w_stateNext   = S_CRASHED;
            w_crashedNext = 1'b1;
          end
        end
        default: begin
          // Crashed: position frozen until reset.
        end
      endcase
    end
  end

  // One-hot column drive decoded from the position register.
  always_comb begin
    lightOn        = '0;
    lightOn[r_pos] = 1'b1;
  end

  assign pos     = r_pos;
  assign crashed = r_crashed;

endmodule
`default_nettype wire

// File: tb/tb_bird_column.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bird_column                                                |
// | Purpose  : Self-checking bench for bird_column; two instances cover the  |
// |            fast-fall/unit-jump and the slow-fall/long-jump settings.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bird_column;

  logic clk = 1'b0;
  logic reset;

  logic       enA, upA, goA;
  logic [7:0] wallA;
  logic [7:0] lightA;
  logic [2:0] posA;
  logic       crA;

  logic       enB, upB, goB;
  logic [7:0] wallB;
  logic [7:0] lightB;
  logic [2:0] posB;
  logic       crB;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    int         sel;
    logic [2:0] pos;
    logic       crashed;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bird_column #(.ROWS(8), .START_ROW(4), .JUMP(1), .FALL_DELAY(1)) dutA (
    .clk(clk), .reset(reset), .enable(enA), .up(upA), .gameOver(goA),
    .wall(wallA), .lightOn(lightA), .pos(posA), .crashed(crA)
  );

  bird_column #(.ROWS(8), .START_ROW(6), .JUMP(3), .FALL_DELAY(3)) dutB (
    .clk(clk), .reset(reset), .enable(enB), .up(upB), .gameOver(goB),
    .wall(wallB), .lightOn(lightB), .pos(posB), .crashed(crB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-clk key press between ticks.
  task automatic pulseUp(input int sel);
    @(negedge clk);
    if (sel == 0) upA = 1'b1; else upB = 1'b1;
    @(negedge clk);
    if (sel == 0) upA = 1'b0; else upB = 1'b0;
  endtask

  // Drive one game tick, queue the expected result, then check the outcome.
  task automatic tick(input int sel, input logic [2:0] expPos, input logic expCr);
    exp_t e;
    exp_t g;
    @(negedge clk);
    if (sel == 0) enA = 1'b1; else enB = 1'b1;
    e.sel = sel; e.pos = expPos; e.crashed = expCr;
    sb.push_back(e);
    @(negedge clk);
    enA = 1'b0; enB = 1'b0;
    g = sb.pop_front();
    if (g.sel == 0) begin
      checkVal("A.pos", 32'(posA), 32'(g.pos));
      checkVal("A.lightOn", 32'(lightA), 32'(8'(1) << g.pos));
      checkVal("A.crashed", 32'(crA), 32'(g.crashed));
    end else begin
      checkVal("B.pos", 32'(posB), 32'(g.pos));
      checkVal("B.lightOn", 32'(lightB), 32'(8'(1) << g.pos));
      checkVal("B.crashed", 32'(crB), 32'(g.crashed));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    enA = 1'b0; upA = 1'b0; goA = 1'b0; wallA = '0;
    enB = 1'b0; upB = 1'b0; goB = 1'b0; wallB = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    checkVal("rst.posA", 32'(posA), 32'd4);
    checkVal("rst.lightA", 32'(lightA), 32'h10);
    checkVal("rst.crA", 32'(crA), 32'd0);
    checkVal("rst.posB", 32'(posB), 32'd6);

    // Idle ticks: no gravity; wall ignored while idle.
    wallA = 8'hFF;
    tick(0, 3'd4, 1'b0);
    wallA = '0;
    repeat (4) tick(0, 3'd4, 1'b0);

    // Launch, fall to the ground, then crash on the next fall.
    pulseUp(0);
    tick(0, 3'd5, 1'b0);
    for (int r = 4; r >= 0; r--) tick(0, 3'(r), 1'b0);
    tick(0, 3'd0, 1'b1);
    pulseUp(0);
    tick(0, 3'd0, 1'b1);
    upA = 1'b1;
    tick(0, 3'd0, 1'b1);
    upA = 1'b0;

    // Ceiling saturation with key held through the ticks.
    doReset();
    upA = 1'b1;
    tick(0, 3'd5, 1'b0);
    tick(0, 3'd6, 1'b0);
    tick(0, 3'd7, 1'b0);
    repeat (3) tick(0, 3'd7, 1'b0);
    upA = 1'b0;

    // Fall to row 3, then hit the pipe in row 2.
    for (int r = 6; r >= 3; r--) tick(0, 3'(r), 1'b0);
    wallA = 8'b0000_0100;
    tick(0, 3'd2, 1'b1);
    wallA = '0;
    tick(0, 3'd2, 1'b1);

    // Freeze: presses between and on frozen ticks are dropped.
    doReset();
    pulseUp(0);
    tick(0, 3'd5, 1'b0);
    goA = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulseUp(0);
      tick(0, 3'd5, 1'b0);
    end
    upA = 1'b1;
    tick(0, 3'd5, 1'b0);
    upA = 1'b0;
    goA = 1'b0;
    tick(0, 3'd4, 1'b0);

    // Slow fall and long jump on instance B.
    doReset();
    pulseUp(1);
    tick(1, 3'd7, 1'b0);
    tick(1, 3'd7, 1'b0);
    tick(1, 3'd7, 1'b0);
    tick(1, 3'd6, 1'b0);
    tick(1, 3'd6, 1'b0);
    upB = 1'b1;
    tick(1, 3'd7, 1'b0);
    upB = 1'b0;
    tick(1, 3'd7, 1'b0);
    tick(1, 3'd7, 1'b0);
    tick(1, 3'd6, 1'b0);

    // Freeze holds the fall counter: one tick before, two after release.
    tick(1, 3'd6, 1'b0);
    goB = 1'b1;
    pulseUp(1);
    tick(1, 3'd6, 1'b0);
    tick(1, 3'd6, 1'b0);
    goB = 1'b0;
    tick(1, 3'd6, 1'b0);
    tick(1, 3'd5, 1'b0);

    // Jump into a pipe: the move happens, then the crash.
    wallB = 8'h80;
    upB = 1'b1;
    tick(1, 3'd7, 1'b1);
    upB = 1'b0;
    wallB = '0;
    tick(1, 3'd7, 1'b1);

    // Put A in flight, then assert reset between clock edges.
    pulseUp(0);
    tick(0, 3'd5, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checkVal("async.posA", 32'(posA), 32'd4);
    checkVal("async.lightA", 32'(lightA), 32'h10);
    checkVal("async.crA", 32'(crA), 32'd0);
    checkVal("async.posB", 32'(posB), 32'd6);
    checkVal("async.crB", 32'(crB), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(0, 3'd4, 1'b0);

    checkVal("sb.empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
